// File: rtl/emu_ioctl_pkg.sv
// Shared definitions for the HPS ioctl transfer channel: upload FSM states,
// transfer index constants and the default fill byte.
package emu_ioctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PAUSE = 3'd1,
    ST_SERVE = 3'd2,
    ST_FETCH = 3'd3,
    ST_DONE  = 3'd4
  } upload_state_e;

  localparam logic [7:0] IOCTL_IDX_ROM      = 8'd0;
  localparam logic [7:0] IOCTL_IDX_MOD      = 8'd1;
  localparam logic [7:0] IOCTL_IDX_NVRAM    = 8'd4;
  localparam logic [7:0] IOCTL_IDX_DIP      = 8'd254;
  localparam logic [7:0] IOCTL_FILL_DEFAULT = 8'hFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ioctl_rd_latency_ctr.sv
// RAM read latency tracker: loaded when a RAM read is issued, raises valid
// during the cycle in which ram_q carries the requested byte.
module ioctl_rd_latency_ctr #(
  parameter int unsigned LAT = 1
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic load,
  output logic valid
);

  localparam logic [1:0] LAT_V = 2'(LAT);

  logic [1:0] cnt_r;
  logic       busy_r;

  // Down-counter: reaches zero exactly LAT cycles after the read enable.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r  <= 2'd0;
      busy_r <= 1'b0;
    end else if (load) begin
      cnt_r  <= LAT_V;
      busy_r <= 1'b1;
    end else if (busy_r) begin
      if (cnt_r == 2'd0) begin
        busy_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r - 2'd1;
      end
    end else begin
      cnt_r  <= cnt_r;
      busy_r <= busy_r;
    end
  end

  assign valid = busy_r && (cnt_r == 2'd0);

endmodule

// File: rtl/ioctl_upload_server.sv
// Serves HPS ioctl upload reads from a synchronous-read core RAM, holding the
// game CPU frozen through a pause handshake while the upload window is open.
module ioctl_upload_server
  import emu_ioctl_pkg::*;
#(
  parameter logic [7:0] INDEX   = IOCTL_IDX_NVRAM,
  parameter int         AW      = 10,
  parameter int         RAM_LAT = 1,
  parameter logic [7:0] FILL    = IOCTL_FILL_DEFAULT
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          pause_req,
  input  logic          pause_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd,
  input  logic [7:0]    ram_q,
  output logic          active,
  output logic          done,
  output logic [15:0]   byte_count
);

  upload_state_e state_r, state_nxt_s;

  logic          sel_s, sel_q_r, sel_rise_s, in_range_s;
  logic          lat_load_s, lat_valid_s;
  logic [7:0]    din_nxt_s;
  logic          wait_nxt_s, pause_nxt_s, ram_rd_nxt_s, active_nxt_s, done_nxt_s;
  logic [AW-1:0] ram_addr_nxt_s;
  logic [15:0]   count_nxt_s;

  assign sel_s      = ioctl_upload && (ioctl_index == INDEX);
  assign sel_rise_s = sel_s && !sel_q_r;
  assign in_range_s = ((ioctl_addr >> AW) == 25'd0);

  ioctl_rd_latency_ctr #(.LAT(RAM_LAT)) u_lat_ctr (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .load    (lat_load_s),
    .valid   (lat_valid_s)
  );

  // State and registered output update.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      sel_q_r    <= 1'b0;
      ioctl_din  <= 8'h00;
      ioctl_wait <= 1'b0;
      pause_req  <= 1'b0;
      ram_addr   <= '0;
      ram_rd     <= 1'b0;
      active     <= 1'b0;
      done       <= 1'b0;
      byte_count <= 16'd0;
    end else begin
      state_r    <= state_nxt_s;
      // Forcing the history low in DONE lets a re-asserted sel register as a new edge in IDLE.
      sel_q_r    <= (state_r == ST_DONE) ? 1'b0 : sel_s;
      ioctl_din  <= din_nxt_s;
      ioctl_wait <= wait_nxt_s;
      pause_req  <= pause_nxt_s;
      ram_addr   <= ram_addr_nxt_s;
      ram_rd     <= ram_rd_nxt_s;
      active     <= active_nxt_s;
      done       <= done_nxt_s;
      byte_count <= count_nxt_s;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nxt_s    = state_r;
    din_nxt_s      = ioctl_din;
    wait_nxt_s     = ioctl_wait;
    pause_nxt_s    = pause_req;
    ram_addr_nxt_s = ram_addr;
    ram_rd_nxt_s   = 1'b0;
    active_nxt_s   = active;
    done_nxt_s     = 1'b0;
    count_nxt_s    = byte_count;
    lat_load_s     = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (sel_rise_s) begin
          state_nxt_s  = ST_PAUSE;
          pause_nxt_s  = 1'b1;
          active_nxt_s = 1'b1;
          wait_nxt_s   = 1'b1;
          count_nxt_s  = 16'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PAUSE: begin
        if (!sel_s) begin
          state_nxt_s  = ST_DONE;
          done_nxt_s   = 1'b1;
          pause_nxt_s  = 1'b0;
          active_nxt_s = 1'b0;
          wait_nxt_s   = 1'b0;
        end else if (pause_ack) begin
          state_nxt_s = ST_SERVE;
          wait_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = ST_PAUSE;
        end
      end
      ST_SERVE: begin
        if (!sel_s) begin
          state_nxt_s  = ST_DONE;
          done_nxt_s   = 1'b1;
          pause_nxt_s  = 1'b0;
          active_nxt_s = 1'b0;
          wait_nxt_s   = 1'b0;
        end else if (ioctl_rd) begin
          count_nxt_s = sat_inc16(byte_count);
          if (in_range_s) begin
            state_nxt_s    = ST_FETCH;
            ram_addr_nxt_s = ioctl_addr[AW-1:0];
            ram_rd_nxt_s   = 1'b1;
            wait_nxt_s     = 1'b1;
            lat_load_s     = 1'b1;
          end else begin
            state_nxt_s = ST_SERVE;
            din_nxt_s   = FILL;
          end
        end else begin
          state_nxt_s = ST_SERVE;
        end
      end
      ST_FETCH: begin
        if (lat_valid_s) begin
          din_nxt_s  = ram_q;
          wait_nxt_s = 1'b0;
          if (!sel_s) begin
            state_nxt_s  = ST_DONE;
            done_nxt_s   = 1'b1;
            pause_nxt_s  = 1'b0;
            active_nxt_s = 1'b0;
          end else begin
            state_nxt_s = ST_SERVE;
          end
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s  = ST_IDLE;
        pause_nxt_s  = 1'b0;
        active_nxt_s = 1'b0;
        wait_nxt_s   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ioctl_upload_server.sv
// Directed bench for ioctl_upload_server: one instance with RAM_LAT=1 and one
// with RAM_LAT=2, sharing the HPS-side stimulus, each with its own RAM model.
module tb_ioctl_upload_server;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic        pause_ack;

  logic [7:0]  din1, din2, q1, q2, stage2;
  logic        wait1, wait2, preq1, preq2, rd1, rd2;
  logic        act1, act2, done1, done2;
  logic [9:0]  raddr1, raddr2;
  logic [15:0] cnt1, cnt2;

  logic [7:0]  mem1 [0:1023];
  logic [7:0]  mem2 [0:1023];

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk_sys = ~clk_sys;

  ioctl_upload_server #(.INDEX(8'd4), .AW(10), .RAM_LAT(1), .FILL(8'hFF)) u_dut1 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(din1), .ioctl_wait(wait1), .pause_req(preq1), .pause_ack(pause_ack),
    .ram_addr(raddr1), .ram_rd(rd1), .ram_q(q1), .active(act1), .done(done1),
    .byte_count(cnt1));

  ioctl_upload_server #(.INDEX(8'd4), .AW(10), .RAM_LAT(2), .FILL(8'hFF)) u_dut2 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(din2), .ioctl_wait(wait2), .pause_req(preq2), .pause_ack(pause_ack),
    .ram_addr(raddr2), .ram_rd(rd2), .ram_q(q2), .active(act2), .done(done2),
    .byte_count(cnt2));

  // One-cycle and two-cycle synchronous-read RAM models.
  always @(posedge clk_sys) begin
    if (rd1) q1 <= mem1[raddr1];
    if (rd2) stage2 <= mem2[raddr2];
    q2 <= stage2;
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ioctl_upload = 1'b0; ioctl_index = 8'd0; ioctl_rd = 1'b0;
    ioctl_addr = 25'd0; pause_ack = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      mem1[i] = 8'(i) ^ 8'h4A;
      mem2[i] = 8'(i) ^ 8'hA5;
    end
    tick(); tick();
    total_cnt++;
    if ({din1, wait1, preq1, raddr1, rd1, act1, done1, cnt1} !== 38'd0)
      $display("FAIL reset_outputs got din=%h wait=%b preq=%b addr=%h rd=%b act=%b done=%b cnt=%0d want all zero",
               din1, wait1, preq1, raddr1, rd1, act1, done1, cnt1);
    else pass_cnt++;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_read();
    int wc, rc;
    ioctl_upload = 1'b1; ioctl_index = 8'd4;
    tick();
    total_cnt++;
    if ({preq1, act1, wait1} !== 3'b111) $display("FAIL pause_entry got preq/act/wait=%b want 111", {preq1, act1, wait1});
    else pass_cnt++;
    tick(); tick();
    total_cnt++;
    if (wait1 !== 1'b1) $display("FAIL pause_hold_wait got %b want 1", wait1); else pass_cnt++;
    pause_ack = 1'b1;
    tick();
    total_cnt++;
    if (wait1 !== 1'b0) $display("FAIL serve_wait got %b want 0", wait1); else pass_cnt++;
    ioctl_rd = 1'b1; ioctl_addr = 25'h010;
    tick();
    ioctl_rd = 1'b0;
    wc = 0; rc = 0;
    for (int k = 0; k < 10; k++) begin
      if (wait1) wc++;
      if (rd1) rc++;
      if (!wait1) break;
      tick();
    end
    total_cnt++;
    if (wc !== 2) $display("FAIL basic_wait_cycles got %0d want 2", wc); else pass_cnt++;
    total_cnt++;
    if (rc !== 1) $display("FAIL basic_ram_rd_pulses got %0d want 1", rc); else pass_cnt++;
    total_cnt++;
    if (din1 !== 8'h5A) $display("FAIL basic_din got %h want 5a", din1); else pass_cnt++;
    total_cnt++;
    if (cnt1 !== 16'd1) $display("FAIL basic_count got %0d want 1", cnt1); else pass_cnt++;
  endtask

  task automatic test_out_of_range();
    ioctl_rd = 1'b1; ioctl_addr = 25'h400;
    tick();
    ioctl_rd = 1'b0;
    total_cnt++;
    if ({din1, wait1, rd1} !== {8'hFF, 1'b0, 1'b0})
      $display("FAIL oor_response got din=%h wait=%b rd=%b want ff 0 0", din1, wait1, rd1);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({wait1, rd1, cnt1} !== {1'b0, 1'b0, 16'd2})
      $display("FAIL oor_after got wait=%b rd=%b cnt=%0d want 0 0 2", wait1, rd1, cnt1);
    else pass_cnt++;
    ioctl_upload = 1'b0;
    tick();
    total_cnt++;
    if ({done1, preq1, act1} !== 3'b100) $display("FAIL oor_done got done/preq/act=%b want 100", {done1, preq1, act1});
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done1 !== 1'b0) $display("FAIL oor_done_pulse got %b want 0", done1); else pass_cnt++;
    pause_ack = 1'b0;
  endtask

  task automatic test_wrong_index();
    int bad;
    bad = 0;
    ioctl_upload = 1'b1; ioctl_index = 8'd0; pause_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ioctl_rd = (k == 2); ioctl_addr = 25'h010;
      tick();
      if (preq1 || wait1 || rd1 || act1 || din1 !== 8'hFF || cnt1 !== 16'd2) bad++;
    end
    ioctl_rd = 1'b0; ioctl_upload = 1'b0; pause_ack = 1'b0;
    tick();
    total_cnt++;
    if (bad !== 0) $display("FAIL wrong_index got %0d disturbed cycles want 0", bad); else pass_cnt++;
  endtask

  task automatic test_stream();
    int wc, bad_data, bad_wait;
    bad_data = 0; bad_wait = 0;
    ioctl_upload = 1'b1; ioctl_index = 8'd4;
    tick();
    pause_ack = 1'b1;
    tick();
    for (int i = 0; i < 1024; i++) begin
      ioctl_rd = 1'b1; ioctl_addr = 25'(i);
      tick();
      ioctl_rd = 1'b0;
      wc = 0;
      for (int k = 0; k < 10; k++) begin
        if (wait2) wc++;
        if (!wait2) break;
        tick();
      end
      if (wc != 3) begin
        bad_wait++;
        if (bad_wait < 4) $display("FAIL stream_wait addr=%0d got %0d want 3", i, wc);
      end
      if (din2 !== (8'(i) ^ 8'hA5)) begin
        bad_data++;
        if (bad_data < 4) $display("FAIL stream_data addr=%0d got %h want %h", i, din2, 8'(i) ^ 8'hA5);
      end
    end
    total_cnt++;
    if (bad_wait !== 0) $display("FAIL stream_wait_total got %0d bad windows want 0", bad_wait); else pass_cnt++;
    total_cnt++;
    if (bad_data !== 0) $display("FAIL stream_data_total got %0d bad bytes want 0", bad_data); else pass_cnt++;
    total_cnt++;
    if (cnt2 !== 16'd1024) $display("FAIL stream_count got %0d want 1024", cnt2); else pass_cnt++;
    ioctl_upload = 1'b0;
    tick();
    total_cnt++;
    if ({done2, preq2, act2} !== 3'b100) $display("FAIL stream_done got done/preq/act=%b want 100", {done2, preq2, act2});
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done2 !== 1'b0) $display("FAIL stream_done_pulse got %b want 0", done2); else pass_cnt++;
    pause_ack = 1'b0;
  endtask

  task automatic test_drop_in_fetch();
    int dc;
    ioctl_upload = 1'b1; ioctl_index = 8'd4;
    tick();
    total_cnt++;
    if (cnt2 !== 16'd0) $display("FAIL drop_count_clear got %0d want 0", cnt2); else pass_cnt++;
    pause_ack = 1'b1;
    tick();
    ioctl_rd = 1'b1; ioctl_addr = 25'h020;
    tick();
    ioctl_rd = 1'b0; ioctl_upload = 1'b0;
    dc = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done2) dc++;
    end
    total_cnt++;
    if (din2 !== 8'h85) $display("FAIL drop_din got %h want 85", din2); else pass_cnt++;
    total_cnt++;
    if (dc !== 1) $display("FAIL drop_done_pulses got %0d want 1", dc); else pass_cnt++;
    total_cnt++;
    if ({preq2, act2, wait2} !== 3'b000) $display("FAIL drop_release got preq/act/wait=%b want 000", {preq2, act2, wait2});
    else pass_cnt++;
    pause_ack = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    int wc;
    ioctl_upload = 1'b1; ioctl_index = 8'd4;
    tick();
    pause_ack = 1'b1;
    tick();
    ioctl_rd = 1'b1; ioctl_addr = 25'h030;
    tick();
    ioctl_rd = 1'b0;
    total_cnt++;
    if ({preq2, wait2, act2} !== 3'b111) $display("FAIL rst_pre got preq/wait/act=%b want 111", {preq2, wait2, act2});
    else pass_cnt++;
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({preq2, wait2, act2, rd2} !== 4'b0000)
      $display("FAIL rst_async got preq/wait/act/rd=%b want 0000", {preq2, wait2, act2, rd2});
    else pass_cnt++;
    ioctl_upload = 1'b0; pause_ack = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    ioctl_upload = 1'b1;
    tick();
    total_cnt++;
    if ({preq2, cnt2} !== {1'b1, 16'd0}) $display("FAIL rst_fresh_pause got preq=%b cnt=%0d want 1 0", preq2, cnt2);
    else pass_cnt++;
    pause_ack = 1'b1;
    tick();
    ioctl_rd = 1'b1; ioctl_addr = 25'h031;
    tick();
    ioctl_rd = 1'b0;
    wc = 0;
    for (int k = 0; k < 10; k++) begin
      if (!wait2) break;
      wc++;
      tick();
    end
    total_cnt++;
    if ({din2, cnt2} !== {8'h94, 16'd1}) $display("FAIL rst_fresh_read got din=%h cnt=%0d want 94 1", din2, cnt2);
    else pass_cnt++;
    total_cnt++;
    if (wc !== 3) $display("FAIL rst_fresh_wait got %0d want 3", wc); else pass_cnt++;
    ioctl_upload = 1'b0; pause_ack = 1'b0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_out_of_range();
    test_wrong_index();
    test_stream();
    test_drop_in_fetch();
    test_reset_mid_fetch();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
